aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  Iterative AES-128 key schedule, directly upstream of encryption_top's round datapath.
//  Loads a 128-bit cipher key and produces one round key per cycle into an 11-entry store.
//  After expansion, the cipher reads round keys by index for as many blocks as it needs.
//  Re-keying is needed only when the key changes.
// PARAMETERS
//  NR       10   number of rounds; the store holds NR+1 keys (only 10 is supported)
//  KEY_W    128  key and round-key width in bits
// PORTS
//  clk         in   1    single clock, rising edge
//  reset       in   1    synchronous, active-high
//  start       in   1    load key and begin expansion (sampled only in IDLE/READY)
//  key         in   128  cipher key, word 0 = key[127:96]; sampled on the accepted start
//  rk_idx      in   4    round-key read index, 0..10
//  rk_out      out  128  round key rk_idx (combinational read of the store)
//  busy        out  1    expansion in progress
//  keys_valid  out  1    all 11 round keys valid for the current key
//  zeroize     in   1    present only with AES_KEYEXP_ZEROIZE_EN
// BEHAVIOUR
//  - Reset values: state=IDLE, busy=0, keys_valid=0, round cnt=0, rcon=8'h01, store all-zero, so rk_out=0.
//  - FSM IDLE -> EXPAND on start; EXPAND -> READY after round 10; READY -> EXPAND on start.
//  - Accept at edge N (start=1, state IDLE/READY): rk[0]<=key, rcon<=01, cnt<=1, keys_valid<=0, busy<=1.
//  - EXPAND at edges N+1..N+10: rk[cnt] is computed from rk[cnt-1]:
//      t=SubWord(RotWord(w3))^{rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//      Then rcon<=xtime(rcon) (0x80->0x1B) and cnt<=cnt+1.
//  - At edge N+10: busy<=0, keys_valid<=1, state<=READY. Latency from accepted start to keys_valid=1 is 10 cycles later.
//  - start while EXPAND: ignored; expansion continues unchanged; key is not re-sampled.
//  - start held high in READY: re-expansion every 11 cycles. keys_valid drops for 10 cycles each time.
//  - rk_idx 11..15: rk_out=0. A read during EXPAND returns whatever the store holds; the
//    consumer qualifies reads with keys_valid.
//  - A reset asserted mid-expansion aborts expansion: reset values apply at the next edge.
//  - A reset that coincides with start: reset wins and the start is dropped.
//  - All arithmetic is GF(2^8) XOR/xtime; there are no carries; cnt is 4 bits and never exceeds 10.
// CONFIGURATION
//  AES_KEYEXP_ZEROIZE_EN defined:
//    - zeroize port exists. zeroize=1 at an edge clears the whole store, keys_valid<=0, busy<=0, state<=IDLE.
//    - Priority: reset > zeroize > start.
//  AES_KEYEXP_ZEROIZE_EN undefined:
//    - no zeroize port; the store is cleared only by reset.
// STRUCTURE
//  - aes_pkg (shared with encryption_top):
//      SBOX[256] constant, xtime function.
//      typedef word_t (32b), typedef state_t (128b).
//      constants AES_NR=10 and RCON_INIT=8'h01.
//  - Sub-module aes_sbox: combinational 8->8 lookup from aes_pkg::SBOX, instantiated 4x for SubWord.
//    The cipher's SubBytes reuses the same aes_sbox.
//  - The store is an 11x128 flop array with a write port (rk[0] on load, rk[cnt] during EXPAND).
// TESTING
//  1. FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start 1 cycle
//     -> keys_valid after 10 cycles; rk1=a0fafe17_88542cb1_23a33939_2a6c7605;
//        rk10=d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
//  2. All-zero key
//     -> rk1=62636363_62636363_62636363_62636363; rk10=b4ef5bcb_3e92e211_23e951cf_6f8f188e;
//        rk_idx=12 -> rk_out=0.
//  3. Start the FIPS key, pulse start with the zero key at expansion cycle 4
//     -> ignored; rk10 still d014f9a8...; keys_valid after the original 10 cycles.
//  4. Assert reset at expansion cycle 5
//     -> next cycle busy=0, keys_valid=0, rk_out=0 for all idx; a new start then completes normally.
//  5. In READY with the FIPS keys, start with the zero key
//     -> keys_valid=0 for 10 cycles, then rk10=b4ef5bcb...
//  6. (AES_KEYEXP_ZEROIZE_EN) zeroize in READY -> next cycle keys_valid=0, rk_out=0 for idx 0..10.
//     zeroize together with start -> the store stays zero and state=IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key schedule and encryption_top.
// The optional zeroize feature of aes_key_expand is enabled with AES_KEYEXP_ZEROIZE_EN.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } kx_state_t;

    // Forward S-box, entry 0 in the most significant byte of the first row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Control/read bus between the key schedule and the cipher datapath.
// The zeroize signal exists only when AES_KEYEXP_ZEROIZE_EN is defined.
interface aes_key_expand_if;

    logic            start;
    aes_pkg::state_t key;
    logic [3:0]      rk_idx;
    aes_pkg::state_t rk_out;
    logic            busy;
    logic            keys_valid;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic            zeroize;

    modport master (output start, key, rk_idx, zeroize, input rk_out, busy, keys_valid);
    modport slave  (input start, key, rk_idx, zeroize, output rk_out, busy, keys_valid);
`else
    modport master (output start, key, rk_idx, input rk_out, busy, keys_valid);
    modport slave  (input start, key, rk_idx, output rk_out, busy, keys_valid);
`endif

endinterface

// File: rtl/aes_sbox.sv
// Combinational 8->8 AES S-box lookup, shared by SubWord and SubBytes.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry store.
// Define AES_KEYEXP_ZEROIZE_EN to add the zeroize input (priority reset > zeroize > start).
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = 128
) (
    input logic          clk,
    input logic          reset,
    aes_key_expand_if.slave bus
);

    kx_state_t        state;
    kx_state_t        nxt;
    logic [3:0]       cnt;
    logic [7:0]       rcon;
    logic [KEY_W-1:0] store [0:NR];

    logic             zero_req;
    logic             accept;
    logic             last;
    logic [3:0]       prev_idx;
    logic [KEY_W-1:0] prev_rk;
    word_t            rot_w;
    word_t            sub_w;
    word_t            t_w;
    word_t            w0n, w1n, w2n, w3n;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign zero_req = bus.zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign accept = bus.start && !zero_req && (state == IDLE || state == READY);
    assign last   = (state == EXPAND) && (cnt == 4'(NR));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (zero_req) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE, READY: if (bus.start) nxt = EXPAND;
                EXPAND:      if (last) nxt = READY;
                default:     nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy       = (state == EXPAND);
        bus.keys_valid = (state == READY);
    end

    // One schedule step: derive rk[cnt] from rk[cnt-1].
    assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    assign prev_rk  = store[prev_idx];
    assign rot_w    = {prev_rk[23:0], prev_rk[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            aes_sbox u_sbox (
                .din  (rot_w[8*g +: 8]),
                .dout (sub_w[8*g +: 8])
            );
        end
    endgenerate

    assign t_w = sub_w ^ {rcon, 24'h0};
    assign w0n = prev_rk[127:96] ^ t_w;
    assign w1n = prev_rk[95:64]  ^ w0n;
    assign w2n = prev_rk[63:32]  ^ w1n;
    assign w3n = prev_rk[31:0]   ^ w2n;

    always_ff @(posedge clk) begin
        if (reset || zero_req) begin
            cnt  <= 4'd0;
            rcon <= RCON_INIT;
            for (int i = 0; i <= NR; i++) store[i] <= '0;
        end else if (accept) begin
            store[0] <= bus.key;
            rcon     <= RCON_INIT;
            cnt      <= 4'd1;
        end else if (state == EXPAND) begin
            store[cnt] <= {w0n, w1n, w2n, w3n};
            rcon       <= xtime(rcon);
            if (!last) cnt <= cnt + 4'd1;
        end
    end

    // Indices beyond the last round key read as zero.
    assign bus.rk_out = (bus.rk_idx <= 4'(NR)) ? store[bus.rk_idx] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-level FIPS-197 key schedule model.
module tb_aes_key_expand;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic reset;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic [7:0] refSbox [256];

    always #5 clk = ~clk;

    aes_key_expand_if bus ();

    aes_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box built from the multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic buildSbox;
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gfMul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            refSbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] modelKey(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {refSbox[t[31:24]], refSbox[t[23:16]], refSbox[t[15:8]], refSbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gfMul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] k);
        bus.key   = k;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic readKey(input int idx, output logic [127:0] v);
        bus.rk_idx = 4'(idx);
        #1;
        v = bus.rk_out;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!bus.keys_valid && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic checkAllKeys(input string tag, input logic [127:0] k);
        logic [127:0] v;
        for (int r = 0; r <= 10; r++) begin
            readKey(r, v);
            checkOutput($sformatf("%s_rk%0d", tag, r), v, modelKey(k, r));
        end
    endtask

    task automatic checkAllZero(input string tag);
        logic [127:0] v;
        for (int r = 0; r <= 10; r++) begin
            readKey(r, v);
            checkOutput($sformatf("%s_rk%0d", tag, r), v, '0);
        end
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] rk;
        int cyc;

        buildSbox();
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.key    = '0;
        bus.rk_idx = 4'd0;
`ifdef AES_KEYEXP_ZEROIZE_EN
        bus.zeroize = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("reset_busy", 128'(bus.busy), 128'd0);
        checkOutput("reset_valid", 128'(bus.keys_valid), 128'd0);
        checkAllZero("reset");

        // FIPS-197 key
        applyStimulus(FIPS_KEY);
        checkOutput("fips_busy_after_accept", 128'(bus.busy), 128'd1);
        checkOutput("fips_valid_after_accept", 128'(bus.keys_valid), 128'd0);
        waitValid(cyc);
        checkOutput("fips_latency", 128'(cyc), 128'd10);
        checkOutput("fips_busy_done", 128'(bus.busy), 128'd0);
        readKey(1, v);
        checkOutput("fips_rk1_const", v, FIPS_RK1);
        readKey(10, v);
        checkOutput("fips_rk10_const", v, FIPS_RK10);
        checkAllKeys("fips", FIPS_KEY);

        // All-zero key and out-of-range indices
        applyStimulus('0);
        waitValid(cyc);
        checkOutput("zero_latency", 128'(cyc), 128'd10);
        readKey(1, v);
        checkOutput("zero_rk1_const", v, ZERO_RK1);
        readKey(10, v);
        checkOutput("zero_rk10_const", v, ZERO_RK10);
        readKey(12, v);
        checkOutput("zero_idx12", v, '0);
        readKey(15, v);
        checkOutput("zero_idx15", v, '0);

        // Start during expansion is ignored
        applyStimulus(FIPS_KEY);
        for (int i = 0; i < 3; i++) tick();
        bus.key   = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("ignore_busy", 128'(bus.busy), 128'd1);
        waitValid(cyc);
        checkOutput("ignore_remaining", 128'(cyc), 128'd6);
        readKey(10, v);
        checkOutput("ignore_rk10", v, FIPS_RK10);
        checkAllKeys("ignore", FIPS_KEY);

        // Re-key from READY with the zero key
        applyStimulus('0);
        checkOutput("rekey_valid_drop", 128'(bus.keys_valid), 128'd0);
        waitValid(cyc);
        checkOutput("rekey_latency", 128'(cyc), 128'd10);
        readKey(10, v);
        checkOutput("rekey_rk10", v, ZERO_RK10);

        // Reset mid-expansion
        rk = {$urandom(), $urandom(), $urandom(), $urandom()};
        applyStimulus(rk);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 128'(bus.busy), 128'd0);
        checkOutput("abort_valid", 128'(bus.keys_valid), 128'd0);
        checkAllZero("abort");
        applyStimulus(rk);
        waitValid(cyc);
        checkOutput("abort_restart_latency", 128'(cyc), 128'd10);
        checkAllKeys("abort_restart", rk);

        // Reset coinciding with start
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.key   = FIPS_KEY;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        checkOutput("rst_start_busy", 128'(bus.busy), 128'd0);
        readKey(0, v);
        checkOutput("rst_start_rk0", v, '0);
        tick();
        checkOutput("rst_start_idle", 128'(bus.busy), 128'd0);

        // Start held high: re-expansion every 11 cycles
        bus.key   = FIPS_KEY;
        bus.start = 1'b1;
        tick();
        waitValid(cyc);
        checkOutput("held_first_latency", 128'(cyc), 128'd10);
        tick();
        bus.start = 1'b0;
        checkOutput("held_reaccept_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("held_reaccept_busy", 128'(bus.busy), 128'd1);
        waitValid(cyc);
        checkOutput("held_second_latency", 128'(cyc), 128'd10);
        readKey(10, v);
        checkOutput("held_rk10", v, FIPS_RK10);

        // Random keys against the model
        for (int n = 0; n < 4; n++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(rk);
            waitValid(cyc);
            checkOutput($sformatf("rand%0d_latency", n), 128'(cyc), 128'd10);
            checkAllKeys($sformatf("rand%0d", n), rk);
        end

`ifdef AES_KEYEXP_ZEROIZE_EN
        // Zeroize in READY, then zeroize together with start
        bus.zeroize = 1'b1;
        tick();
        bus.zeroize = 1'b0;
        checkOutput("zeroize_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("zeroize_busy", 128'(bus.busy), 128'd0);
        checkAllZero("zeroize");
        applyStimulus(FIPS_KEY);
        waitValid(cyc);
        checkOutput("zeroize_restart_latency", 128'(cyc), 128'd10);
        bus.zeroize = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.zeroize = 1'b0;
        bus.start   = 1'b0;
        checkOutput("zs_busy", 128'(bus.busy), 128'd0);
        checkOutput("zs_valid", 128'(bus.keys_valid), 128'd0);
        checkAllZero("zs");
        tick();
        checkOutput("zs_idle", 128'(bus.busy), 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
